btb_update_queue: RTL and testbench
===================================

Name: btb_update_queue

Overview:
- Buffers resolved-branch updates coming from the branch stack and drains them, one per cycle, into the BTB write port.
- Decouples branch resolution bursts from BTB write availability.
- Coalesces back-to-back updates to the same branch PC so the BTB only sees the newest target/direction.
- Sits between branch stack (producer) and btb (consumer).

Parameters:
- DEPTH, 8, number of queued updates; power of two, >= 2.
- PTR_W, $clog2(DEPTH), head/tail pointer width (derived; not overridden).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- resolving_valid  input  1  branch stack presents a resolved branch this cycle.
- resolving_PC  input  ADDR  PC of the resolved branch.
- resolving_target_PC  input  ADDR  resolved target address.
- resolving_taken  input  1  actual direction.
- resolving_ready  output  1  queue can accept (combinational: count != DEPTH).
- btb_wr_valid  output  1  head entry valid (count != 0).
- btb_wr_PC  output  ADDR  head entry PC.
- btb_wr_target_PC  output  ADDR  head entry target.
- btb_wr_taken  output  1  head entry direction.
- btb_wr_ready  input  1  BTB accepts the write this cycle.
- queue_count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: head=tail=0, count=0, all entry fields 0. Outputs: btb_wr_valid=0, btb_wr_PC/target=0, btb_wr_taken=0, resolving_ready=1, queue_count=0.
- push = resolving_valid & resolving_ready; pop = btb_wr_valid & btb_wr_ready.
- Output fields are driven directly from entry[head]; no input-to-output bypass. An entry pushed in cycle t is first visible on btb_wr_* in cycle t+1 (min latency 1).
- Pop: head <= head+1 (mod DEPTH), count decrements.
- Push, normal: entry[tail] <= {PC, target, taken}; tail <= tail+1 (mod DEPTH); count increments.
- Push, coalesce: taken when count!=0, entry[tail-1].PC == resolving_PC, and NOT (count==1 & pop).
  - Overwrites entry[tail-1] target/taken in place.
  - tail and count are unchanged by the push.
  - If pop also occurs, count still decrements.
- Coalesce when count==1 & pop: the head entry is leaving, so the push is a normal enqueue.
- Simultaneous normal push and pop: count unchanged; both pointers advance.
- Full (count==DEPTH): resolving_ready=0, even if a pop occurs that cycle (no push-through). Coalescing is also not performed when full.
- Empty: btb_wr_valid=0; btb_wr_ready is ignored. Output fields show stale entry[head] and must not be consumed.
- Pointer wrap: DEPTH-1 -> 0. count distinguishes full from empty.
- Not-taken branches are enqueued like taken ones; the BTB decides what to write.
- resolving_valid while not ready: the update is dropped by the queue. The branch stack must hold the request; the queue keeps no memory of it.
- Reset mid-operation: all queued updates are discarded; the state above is restored next cycle.
- No X on outputs after reset, in any state.

Decomposition:
- In sys_defs.svh:
  - `define BTB_UPDQ_DEPTH 8.
  - typedef struct packed { ADDR PC; ADDR target_PC; logic taken; } BTB_UPDATE_PACKET.
  - Under `ifdef DEBUG, a BTB_UPDQ_DEBUG struct carrying head, tail, count and the entries.
- Sub-modules: none required; a single module with the entry array, pointers and count.

Test Plan:
1. Reset, then idle: btb_wr_valid=0, resolving_ready=1, queue_count=0 for 5 cycles.
2. Push {PC=0x100, tgt=0x200, T}, btb_wr_ready=1:
   - cycle+1: btb_wr_valid=1 with 0x100/0x200/1.
   - cycle+2: valid=0, count=0.
3. btb_wr_ready=0, push 8 distinct PCs 0x000..0x01C:
   - count=8, resolving_ready=0.
   - 9th push (0x020) is held off by ready=0.
   - Raise btb_wr_ready: drains in order 0x000..0x01C, 1 per cycle, across the head wrap.
4. btb_wr_ready=0, push {0x40, 0x80, T}, then {0x40, 0xC0, NT}: count=1; head shows 0x40/0xC0/0 (coalesced).
5. count=1 holding {0x40, 0x80}; same cycle pop and push {0x40, 0xC0}: next cycle count=1, head=0x40/0xC0 (normal enqueue, not coalesce).
6. Assert reset with count=5: next cycle count=0, btb_wr_valid=0, resolving_ready=1.

Source files
------------

// File: rtl/btb_update_queue_pkg.sv
// Shared types for the BTB update queue: address type, update packet, default depth.
package btb_update_queue_pkg;

    localparam int XLEN           = 32;
    localparam int BTB_UPDQ_DEPTH = 8;

    typedef logic [XLEN-1:0] ADDR;

    typedef struct packed {
        ADDR  PC;
        ADDR  target_PC;
        logic taken;
    } BTB_UPDATE_PACKET;

`ifdef DEBUG
    typedef struct packed {
        logic [$clog2(BTB_UPDQ_DEPTH)-1:0] head;
        logic [$clog2(BTB_UPDQ_DEPTH)-1:0] tail;
        logic [$clog2(BTB_UPDQ_DEPTH):0]   count;
        BTB_UPDATE_PACKET [BTB_UPDQ_DEPTH-1:0] entries;
    } BTB_UPDQ_DEBUG;
`endif

endpackage

// File: rtl/btb_update_queue.sv
// Circular buffer of resolved-branch updates draining one per cycle into the BTB
// write port. A new update whose PC matches the youngest queued entry overwrites
// that entry in place, so the BTB only ever sees the newest target/direction.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter  int DEPTH = BTB_UPDQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,

    input  logic           resolving_valid,
    input  ADDR            resolving_PC,
    input  ADDR            resolving_target_PC,
    input  logic           resolving_taken,
    output logic           resolving_ready,

    output logic           btb_wr_valid,
    output ADDR            btb_wr_PC,
    output ADDR            btb_wr_target_PC,
    output logic           btb_wr_taken,
    input  logic           btb_wr_ready,

    output logic [PTR_W:0] queue_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    BTB_UPDATE_PACKET entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             push;
    logic             pop;
    logic             coalesce;
    logic             enqueue;
    logic [PTR_W-1:0] tail_prev;

    // Handshakes and the coalesce decision. When the only entry is leaving this
    // cycle it cannot be overwritten, so the push becomes a normal enqueue.
    always_comb begin
        resolving_ready = (count != FULL_CNT);
        btb_wr_valid    = (count != '0);
        push            = resolving_valid & resolving_ready;
        pop             = btb_wr_valid & btb_wr_ready;
        tail_prev       = tail - 1'b1;
        coalesce        = push & (count != '0)
                        & (entries[tail_prev].PC == resolving_PC)
                        & ~((count == (PTR_W+1)'(1)) & pop);
        enqueue         = push & ~coalesce;
    end

    // Head entry drives the BTB write port directly; no input bypass.
    always_comb begin
        btb_wr_PC        = entries[head].PC;
        btb_wr_target_PC = entries[head].target_PC;
        btb_wr_taken     = entries[head].taken;
        queue_count      = count;
    end

    // Entry storage: normal enqueue writes at tail, coalesce rewrites the youngest entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (enqueue) begin
            entries[tail] <= '{PC: resolving_PC, target_PC: resolving_target_PC,
                               taken: resolving_taken};
        end else if (coalesce) begin
            entries[tail_prev].target_PC <= resolving_target_PC;
            entries[tail_prev].taken     <= resolving_taken;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + 1'b1;
            end
            if (enqueue) begin
                tail <= tail + 1'b1;
            end
            unique case ({enqueue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: a queue-of-packets reference model,
// directed scenarios followed by randomized traffic.
module tb_btb_update_queue;
    import btb_update_queue_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } upd_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        resolving_valid = 1'b0;
    ADDR         resolving_PC = '0;
    ADDR         resolving_target_PC = '0;
    logic        resolving_taken = 1'b0;
    logic        resolving_ready;
    logic        btb_wr_valid;
    ADDR         btb_wr_PC;
    ADDR         btb_wr_target_PC;
    logic        btb_wr_taken;
    logic        btb_wr_ready = 1'b0;
    logic [3:0]  queue_count;

    int checks = 0;
    int passes = 0;
    upd_t exp_q[$];

    btb_update_queue #(.DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .resolving_valid     (resolving_valid),
        .resolving_PC        (resolving_PC),
        .resolving_target_PC (resolving_target_PC),
        .resolving_taken     (resolving_taken),
        .resolving_ready     (resolving_ready),
        .btb_wr_valid        (btb_wr_valid),
        .btb_wr_PC           (btb_wr_PC),
        .btb_wr_target_PC    (btb_wr_target_PC),
        .btb_wr_taken        (btb_wr_taken),
        .btb_wr_ready        (btb_wr_ready),
        .queue_count         (queue_count)
    );

    always #5 clock = ~clock;

    function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // One clock cycle: drive inputs at negedge, check state against the model,
    // then apply this cycle's push/coalesce to the model.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic tk, input logic wr_rdy);
        bit pop_m;
        @(negedge clock);
        reset               = rst;
        resolving_valid     = v;
        resolving_PC        = pc;
        resolving_target_PC = tgt;
        resolving_taken     = tk;
        btb_wr_ready        = wr_rdy;
        #1;
        check("queue_count", 72'(queue_count), 72'(exp_q.size()));
        check("resolving_ready", 72'(resolving_ready), 72'(exp_q.size() != DEPTH));
        check("btb_wr_valid", 72'(btb_wr_valid), 72'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("head_entry", {btb_wr_PC, btb_wr_target_PC, btb_wr_taken},
                  {exp_q[0].pc, exp_q[0].tgt, exp_q[0].tk});
        if (rst) begin
            exp_q.delete();
        end else begin
            pop_m = (exp_q.size() != 0) && wr_rdy;
            if (v && exp_q.size() != DEPTH) begin
                if (exp_q.size() != 0 && exp_q[exp_q.size()-1].pc == pc
                    && !(exp_q.size() == 1 && pop_m)) begin
                    exp_q[exp_q.size()-1].tgt = tgt;
                    exp_q[exp_q.size()-1].tk  = tk;
                end else begin
                    exp_q.push_back('{pc: pc, tgt: tgt, tk: tk});
                end
            end
        end
    endtask

    task automatic idle(input logic wr_rdy);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, wr_rdy);
    endtask

    // Monitor: every accepted BTB write must match the oldest expected update.
    always @(negedge clock) begin
        upd_t e;
        #4;
        if (!reset && btb_wr_valid && btb_wr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 72'(btb_wr_PC), 72'hFFFF_FFFF_FFFF_FFFF_FF);
            end else begin
                e = exp_q.pop_front();
                check("btb_write", {btb_wr_PC, btb_wr_target_PC, btb_wr_taken},
                      {e.pc, e.tgt, e.tk});
            end
        end
    end

    initial begin
        // 1: reset then idle
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset_wr_pc", 72'(btb_wr_PC), 72'h0);
        check("reset_wr_target", 72'(btb_wr_target_PC), 72'h0);
        check("reset_wr_taken", 72'(btb_wr_taken), 72'h0);
        repeat (5) idle(1'b0);

        // 2: single push drained immediately
        cycle(1'b0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // 3: fill with 8 distinct PCs, attempt a 9th, then drain across the wrap
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'(i % 2), 1'b0);
        cycle(1'b0, 1'b1, 32'h020, 32'h2000, 1'b1, 1'b0);
        check("full_count", 72'(queue_count), 72'd8);
        check("full_not_ready", 72'(resolving_ready), 72'd0);
        repeat (9) idle(1'b1);

        // 4: coalesce into a single waiting entry
        cycle(1'b0, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 32'hC0, 1'b0, 1'b0);
        idle(1'b0);
        check("coalesce_count", 72'(queue_count), 72'd1);
        check("coalesce_head", {btb_wr_PC, btb_wr_target_PC, btb_wr_taken},
              {32'h40, 32'hC0, 1'b0});
        idle(1'b1);
        idle(1'b0);

        // 5: count==1 with pop and same-PC push is a normal enqueue
        cycle(1'b0, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 32'hC0, 1'b1, 1'b1);
        idle(1'b0);
        check("pop_push_count", 72'(queue_count), 72'd1);
        check("pop_push_head", {btb_wr_PC, btb_wr_target_PC},
              {32'h40, 32'hC0});
        idle(1'b1);

        // 6: reset with 5 entries queued
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        check("post_reset_count", 72'(queue_count), 72'd0);
        check("post_reset_valid", 72'(btb_wr_valid), 72'd0);
        check("post_reset_ready", 72'(resolving_ready), 72'd1);

        // Random traffic: small PC set to exercise coalescing, bursty BTB readiness
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  32'h800 + 32'($urandom_range(0, 3) * 4),
                  $urandom,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0));
        end
        repeat (DEPTH + 2) idle(1'b1);
        check("final_drained", 72'(exp_q.size()), 72'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
